// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670-style test-pattern transmitter.
// RGB565 colour-bar table and the FSM/pattern enumerations live here.
package ov7670_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        ACTIVE = 3'd3,
        VFRONT = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        PAT_SOLID   = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_RAMP    = 2'd2,
        PAT_CHECKER = 2'd3
    } pattern_t;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ov7670_pattern_tx_pixel_gen.sv
// Combinational pixel generator: maps (x, y, pattern) to one RGB565 word.
// Only y[5] matters (checker rows); the remaining y bits are intentionally ignored.
module tp_pixel_gen
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int XW       = 10,
    parameter int YW       = 9
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  pattern_t      pattern,
    input  logic [15:0]   solid,
    input  logic          frame_lsb,
    output logic [15:0]   word
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [XW-1:0] bar_idx;
    logic [2:0]    bar_sat;
    logic          unused_y;

    assign unused_y = ^(y & ~(YW'(1) << 5));

    always_comb begin
        bar_idx = x / XW'(BAR_W);
        // Leftover pixels when H_ACTIVE is not a multiple of 8 stay in the last bar.
        bar_sat = (bar_idx > XW'(7)) ? 3'd7 : bar_idx[2:0];
        case (pattern)
            PAT_SOLID:   word = solid;
            PAT_BARS:    word = bar_color(bar_sat);
            PAT_RAMP:    word = {x[7:3], x[7:2], x[7:3]};
            PAT_CHECKER: word = (x[5] ^ y[5] ^ frame_lsb) ? RGB_WHITE : RGB_BLACK;
            default:     word = RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/ov7670_pattern_tx.sv
// OV7670-style camera transmitter: vsync/href/byte stream in sensor timing, RGB565 MSB first.
// All outputs are registered from the next-state values, so they change on the same edge as the FSM.
module ov7670_pattern_tx
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  pattern,
    input  logic [15:0] solid_color,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  dout,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    output logic        busy
);

    localparam int LINE      = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW        = $clog2(LINE);
    localparam int VW        = $clog2(FRAME);
    localparam int ACT_START = V_SYNC + V_BACK;
    localparam int ACT_END   = ACT_START + V_ACTIVE;
    localparam int XW        = ($clog2(H_ACTIVE) < 8) ? 8 : $clog2(H_ACTIVE);
    localparam int YW        = ($clog2(V_ACTIVE) < 6) ? 6 : $clog2(V_ACTIVE);

    tx_state_t   state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    pattern_t    pat_q, pat_d;
    logic [15:0] solid_q, solid_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [7:0]  dout_q, dout_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        busy_q, busy_d;

    logic        start;
    logic        line_end;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d;
    logic [15:0] word;

    // State register and all output/config registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            pat_q        <= PAT_SOLID;
            solid_q      <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            dout_q       <= 8'h00;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            pat_q        <= pat_d;
            solid_q      <= solid_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            dout_q       <= dout_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            busy_q       <= busy_d;
        end
    end

    // Next state and counters; en only matters in IDLE and on the last frame cycle.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        start    = 1'b0;
        line_end = (hcnt_q == HW'(LINE - 1));
        if (state_q == IDLE) begin
            if (en) begin
                start   = 1'b1;
                state_d = VSYNC;
                hcnt_d  = '0;
                vcnt_d  = '0;
            end
        end else begin
            hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
            if (line_end)
                vcnt_d = vcnt_q + 1'b1;
            case (state_q)
                VSYNC:  if (line_end && vcnt_q == VW'(V_SYNC - 1))  state_d = VBACK;
                VBACK:  if (line_end && vcnt_q == VW'(ACT_START - 1)) state_d = ACTIVE;
                ACTIVE: if (line_end && vcnt_q == VW'(ACT_END - 1))   state_d = VFRONT;
                VFRONT: begin
                    if (line_end && vcnt_q == VW'(FRAME - 1)) begin
                        vcnt_d = '0;
                        if (en) begin
                            start   = 1'b1;
                            state_d = VSYNC;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign x_d = XW'(hcnt_d >> 1);
    assign y_d = YW'(vcnt_d - VW'(ACT_START));

    tp_pixel_gen #(
        .H_ACTIVE (H_ACTIVE),
        .XW       (XW),
        .YW       (YW)
    ) u_pixel_gen (
        .x         (x_d),
        .y         (y_d),
        .pattern   (pat_d),
        .solid     (solid_d),
        .frame_lsb (frame_cnt_q[0]),
        .word      (word)
    );

    // Outputs for the cycle the FSM is about to enter.
    always_comb begin
        pat_d   = pat_q;
        solid_d = solid_q;
        if (start) begin
            pat_d   = pattern_t'(pattern);
            solid_d = solid_color;
        end
        vsync_d      = (state_d == VSYNC);
        busy_d       = (state_d != IDLE);
        href_d       = (state_d == ACTIVE) && (hcnt_d < HW'(2 * H_ACTIVE));
        frame_done_d = (state_d == VFRONT) && (vcnt_d == VW'(FRAME - 1)) &&
                       (hcnt_d == HW'(LINE - 1));
        frame_cnt_d  = frame_cnt_q + {7'd0, frame_done_d};
        dout_d       = 8'h00;
        if (href_d)
            dout_d = hcnt_d[0] ? word[7:0] : word[15:8];
    end

    assign vsync      = vsync_q;
    assign href       = href_q;
    assign dout       = dout_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ov7670_pattern_tx.sv
// Self-checking bench: per-cycle timing model for sync/busy plus a byte scoreboard for dout.
module tb_ov7670_pattern_tx;

    localparam int H_ACTIVE  = 16;
    localparam int H_BLANK   = 4;
    localparam int V_SYNC    = 1;
    localparam int V_BACK    = 2;
    localparam int V_ACTIVE  = 4;
    localparam int V_FRONT   = 1;
    localparam int LINE      = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_CYC = LINE * (V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
    localparam int ACT0      = LINE * (V_SYNC + V_BACK);

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic [15:0] solid_color = 16'h0000;
    logic        vsync, href, frame_done, busy;
    logic [7:0]  dout, frame_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_fcnt = 8'd0;
    bit          mon_on = 1'b0;

    always #5 pclk = ~pclk;

    ov7670_pattern_tx #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT)
    ) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .en          (en),
        .pattern     (pattern),
        .solid_color (solid_color),
        .vsync       (vsync),
        .href        (href),
        .dout        (dout),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_word(input int pat, input logic [15:0] sc,
                                               input int x, input int y, input logic f);
        logic [15:0] bars [8];
        logic [7:0]  xb, yb;
        int          b;
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        xb = 8'(x);
        yb = 8'(y);
        b  = x / (H_ACTIVE / 8);
        if (b > 7) b = 7;
        case (pat)
            0:       return sc;
            1:       return bars[b];
            2:       return {xb[7:3], xb[7:2], xb[7:3]};
            default: return (xb[5] ^ yb[5] ^ f) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic push_frame(input int pat, input logic [15:0] sc, input logic f);
        logic [15:0] w;
        for (int y = 0; y < V_ACTIVE; y++)
            for (int x = 0; x < H_ACTIVE; x++) begin
                w = model_word(pat, sc, x, y, f);
                exp_q.push_back(w[15:8]);
                exp_q.push_back(w[7:0]);
            end
    endtask

    task automatic start_frame(input int pat, input logic [15:0] sc);
        @(negedge pclk);
        en          = 1'b1;
        pattern     = 2'(pat);
        solid_color = sc;
        push_frame(pat, sc, exp_fcnt[0]);
    endtask

    // Cycle 0 is the first cycle after the edge that started the frame.
    task automatic watch_frame(input int drop_at);
        for (int c = 0; c < FRAME_CYC; c++) begin
            @(negedge pclk);
            if (c == 0) chk("frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
            chk("vsync", 32'(vsync), 32'(c < LINE * V_SYNC));
            chk("href", 32'(href), 32'(c >= ACT0 && c < ACT0 + V_ACTIVE * LINE &&
                                      ((c - ACT0) % LINE) < 2 * H_ACTIVE));
            chk("frame_done", 32'(frame_done), 32'(c == FRAME_CYC - 1));
            chk("busy", 32'(busy), 32'd1);
            if (c == drop_at) begin
                en          = 1'b0;
                pattern     = ~pattern;
                solid_color = ~solid_color;
            end
        end
        exp_fcnt++;
    endtask

    task automatic idle_chk(input int n);
        repeat (n) begin
            @(negedge pclk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_vsync", 32'(vsync), 32'd0);
            chk("idle_fdone", 32'(frame_done), 32'd0);
        end
    endtask

    always @(negedge pclk) begin
        if (mon_on) begin
            if (href) begin
                if (exp_q.size() == 0) chk("sb_underrun", 32'd1, 32'd0);
                else chk("dout", 32'(dout), 32'(exp_q.pop_front()));
            end else begin
                chk("dout_blank", 32'(dout), 32'd0);
            end
        end
    end

    initial begin
        #12;
        chk("rst_vsync", 32'(vsync), 32'd0);
        chk("rst_href", 32'(href), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        @(negedge pclk);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        idle_chk(5);

        // Solid colour, en pulsed for one cycle.
        start_frame(0, 16'hF81F);
        watch_frame(0);
        idle_chk(1);
        chk("fcnt_after_solid", 32'(frame_cnt), 32'd1);
        idle_chk(3);

        // Colour bars.
        start_frame(1, 16'h0000);
        watch_frame(0);
        idle_chk(4);

        // Checkerboard, three frames back to back.
        start_frame(3, 16'h0000);
        watch_frame(-1);
        push_frame(3, 16'h0000, exp_fcnt[0]);
        watch_frame(-1);
        push_frame(3, 16'h0000, exp_fcnt[0]);
        watch_frame(0);
        idle_chk(1);
        chk("fcnt_after_chk", 32'(frame_cnt), 32'd5);
        idle_chk(3);

        // Ramp; en drop and pattern change mid-frame must not disturb it.
        start_frame(2, 16'h0000);
        watch_frame(150);
        idle_chk(4);
        chk("fcnt_after_ramp", 32'(frame_cnt), 32'(exp_fcnt));

        // Async reset in the middle of ACTIVE.
        start_frame(0, 16'h1234);
        for (int c = 0; c <= 120; c++) begin
            @(negedge pclk);
            if (c == 0) en = 1'b0;
        end
        chk("pre_rst_href", 32'(href), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vsync", 32'(vsync), 32'd0);
        chk("mid_rst_href", 32'(href), 32'd0);
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fcnt", 32'(frame_cnt), 32'd0);
        exp_q.delete();
        exp_fcnt = 8'd0;
        @(negedge pclk);
        rst_n = 1'b1;
        idle_chk(20);

        // 256 frames back to back: frame_cnt wraps to 0.
        start_frame(3, 16'h0000);
        for (int k = 0; k < 256; k++) begin
            if (k > 0) push_frame(3, 16'h0000, exp_fcnt[0]);
            watch_frame((k == 255) ? 0 : -1);
        end
        idle_chk(1);
        chk("fcnt_wrap", 32'(frame_cnt), 32'd0);
        idle_chk(3);

        chk("sb_left", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
